mul_sequencer: RTL
==================

# mul_sequencer

Sequential shift-add multiplier datapath that sits directly upstream of the `Control` block. It accepts an operand pair on a start handshake and drives `counting` into `Control` for the whole operation. It performs one shift-add step per clock while counting, and finishes when `Control` returns `ready`. It holds the product with a valid/ack handshake and flags any disagreement between its own step count and the cycle `Control` reports ready.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The product is `2*WIDTH` bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low. Asserting it forces IDLE immediately.
- `start`  in  1  request a new multiply; sampled only in IDLE.
- `multiplicand`  in  WIDTH  unsigned operand A, captured with `start`.
- `multiplier`  in  WIDTH  unsigned operand B, captured with `start`.
- `ready`  in  1  from `Control`: counting is complete.
- `counting`  out  1  to `Control`: high exactly while in RUN.
- `busy`  out  1  high in RUN and DONE.
- `product`  out  2*WIDTH  result; stable while `valid` is high.
- `valid`  out  1  result available; high in DONE.
- `ack`  in  1  consumer takes the result; sampled only in DONE.
- `err`  out  1  step count was not WIDTH at finish, or a timeout occurred; valid only with `valid`.

## Operation
- **States:** IDLE, RUN, DONE (2-bit encoding).
- **IDLE:**
  - `start`=1 loads `hi`=0 (WIDTH+1 bits, including the carry), `lo`=`multiplier`, `mcand`=`multiplicand`, and `steps`=0.
  - Next state is RUN.
- **RUN, step edge** (`ready`=0 and `steps` < 2*WIDTH):
  - `sum` = `hi[WIDTH-1:0]` + (`lo[0]` ? `mcand` : 0), computed WIDTH+1 bits wide.
  - `{hi,lo}` ← `{sum,lo}` >> 1, which is 2*WIDTH+1 bits shifted right by one with the carry retained.
  - `steps`++.
- **RUN, `ready`=1:**
  - No step is performed.
  - `product` ← `{hi[WIDTH-1:0],lo}`.
  - `err` ← (`steps` != WIDTH).
  - Next state is DONE.
- **RUN, timeout** (`steps` == 2*WIDTH and `ready`=0):
  - `product` ← current value.
  - `err` ← 1.
  - Next state is DONE.
- **DONE:** `ack`=1 → IDLE. `product` and `err` hold their values until the next `start` is accepted.
- **Ignored inputs:** `start` outside IDLE is ignored. `ready` outside RUN is ignored. `ack` outside DONE is ignored.
- **Width rule:** `steps` is $clog2(2*WIDTH)+1 bits. All arithmetic is unsigned and there is no overflow, because a WIDTH×WIDTH product always fits in 2*WIDTH bits.
- **Reset:** every register clears, including mid-RUN; the partial result is discarded.

## Timing
- **Reset values:** `counting`=0, `busy`=0, `valid`=0, `err`=0, `product`=0, state IDLE.
- **Start to RUN:** `start` sampled at edge t → `counting`=`busy`=1 from t+ until RUN exits.
- **RUN duration:** the first step occurs at edge t+1. With `ready` first high at edge t+1+W, exactly W steps have been performed.
- **Finish:** `valid` rises after that edge and `counting` falls on the same edge.
- **Total latency:** start edge to `valid` is WIDTH+1 cycles when `Control` reports `ready` after WIDTH counting cycles.
- **Release:** `ack` at edge u → `valid`=`busy`=0 after u. The earliest accepted next `start` is at edge u+1.
- **Simultaneous events:**
  - `ready` together with the timeout condition is treated as the `ready` path: `err` = (`steps` != WIDTH), which evaluates to 1.
  - `start` together with `ack` in DONE: `ack` wins and `start` is dropped.
- **Reset timing:** `rst` low takes effect without waiting for a clock edge. Release is synchronised by the global reset scheme; the block needs no extra logic for it.

## Structure
- **Shared package `mul_pkg`:**
  - state enum `mul_state_t` {IDLE, RUN, DONE}.
  - `STEP_W` function/constant.
  - default `WIDTH` localparam.
- **Sub-module `mul_step`:** the combinational one-step shift-add, with inputs `hi`, `lo`, `mcand` and outputs `next_hi`, `next_lo`. It is instantiated once. The FSM, step counter and output registers live in `mul_sequencer`.

## Test plan
Benches use WIDTH=8 and a behavioural `Control` model that raises `ready` after N counting cycles.
- **Reset:** `rst`=0 mid-simulation → all outputs 0 asynchronously, before the next `clk` edge.
- **Basic multiply:** A=13, B=11, N=8 → `product`=143, `valid`=1, `err`=0, `counting` high for exactly 8 cycles, latency 9 cycles from start.
- **Carry path:** A=255, B=255, N=8 → `product`=65025, `err`=0. Then A=0, B=200 → `product`=0.
- **Early ready:** A=3, B=5, N=5 → `valid`=1, `err`=1, `counting` falls after 5 steps.
- **Timeout:** `ready` never asserted → after 16 steps `valid`=1, `err`=1, `counting`=0. Then `ack` → IDLE.
- **Protocol:** `start` pulsed during RUN and DONE is ignored (the product is unchanged). `rst` asserted at step 4 → IDLE, `counting`=0. A following start of 7×9 yields 63.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier sequencer.
//   mul_state_t   : sequencer state (IDLE / RUN / DONE), 2-bit encoding
//   DEFAULT_WIDTH : default operand width
//   step_w()      : width of the step counter for a given operand width
package mul_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // The counter must reach 2*width (the timeout value), hence the extra bit.
  function automatic int step_w(input int width);
    return $clog2(2 * width) + 1;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One combinational shift-add step of an unsigned sequential multiplier.
//   hi      in  WIDTH+1  upper partial product (carry in the top bit)
//   lo      in  WIDTH    lower partial product / remaining multiplier bits
//   mcand   in  WIDTH    multiplicand
//   next_hi out WIDTH+1  upper half after add and shift
//   next_lo out WIDTH    lower half after add and shift
module mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH:0]   next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0] w_addend;
  logic [WIDTH:0] w_sum;

  assign w_addend = {1'b0, (lo[0] ? mcand : '0)};
  // hi[WIDTH] is always zero at the start of a step (cleared at load, and the
  // shift below refills it with zero), so adding the full hi equals adding
  // hi[WIDTH-1:0]; the WIDTH+1-bit sum keeps the carry.
  assign w_sum    = hi + w_addend;

  // {sum, lo} >> 1 with the carry retained: sum's LSB moves into lo's MSB.
  assign next_hi  = {1'b0, w_sum[WIDTH:1]};
  assign next_lo  = {w_sum[0], lo[WIDTH-1:1]};

endmodule

// File: rtl/mul_sequencer.sv
// Sequential shift-add multiplier sitting upstream of the Control block.
//   clk          in  1        clock, rising edge
//   rst          in  1        asynchronous active-low reset
//   start        in  1        begin a multiply (sampled in IDLE)
//   multiplicand in  WIDTH    operand A
//   multiplier   in  WIDTH    operand B
//   ready        in  1        Control: counting complete (sampled in RUN)
//   counting     out 1        to Control: high while in RUN
//   busy         out 1        high in RUN and DONE
//   product      out 2*WIDTH  result, stable while valid
//   valid        out 1        result available (DONE)
//   ack          in  1        consumer takes the result (sampled in DONE)
//   err          out 1        step count mismatch or timeout; qualifies valid
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 ready,
  output logic                 counting,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   product,
  output logic                 valid,
  input  logic                 ack,
  output logic                 err
);

  localparam int                STEP_W    = step_w(WIDTH);
  localparam logic [STEP_W-1:0] MAX_STEPS = STEP_W'(2 * WIDTH);
  localparam logic [STEP_W-1:0] EXP_STEPS = STEP_W'(WIDTH);

  mul_state_t           r_state;
  mul_state_t           w_next_state;
  logic [WIDTH:0]       r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_mcand;
  logic [STEP_W-1:0]    r_steps;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_err;
  logic [WIDTH:0]       w_next_hi;
  logic [WIDTH-1:0]     w_next_lo;
  logic                 w_timeout;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .hi      (r_hi),
    .lo      (r_lo),
    .mcand   (r_mcand),
    .next_hi (w_next_hi),
    .next_lo (w_next_lo)
  );

  assign w_timeout = (r_steps == MAX_STEPS);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic. ready wins over a simultaneous timeout and ack wins
  // over start in DONE simply because start is only looked at in IDLE.
  always_comb begin
    // NOTE: default first so no path leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (ready || w_timeout) w_next_state = DONE;
      DONE:    if (ack) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    counting = 1'b0;
    busy     = 1'b0;
    valid    = 1'b0;
    case (r_state)
      RUN: begin
        counting = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        busy  = 1'b1;
        valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operand load, one step per RUN cycle, result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_mcand   <= '0;
      r_steps   <= '0;
      r_product <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_hi    <= '0;
            r_lo    <= multiplier;
            r_mcand <= multiplicand;
            r_steps <= '0;
          end
        end
        RUN: begin
          if (ready) begin
            r_product <= {r_hi[WIDTH-1:0], r_lo};
            r_err     <= (r_steps != EXP_STEPS);
          end else if (w_timeout) begin
            r_product <= {r_hi[WIDTH-1:0], r_lo};
            r_err     <= 1'b1;
          end else begin
            r_hi    <= w_next_hi;
            r_lo    <= w_next_lo;
            r_steps <= r_steps + STEP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;
  assign err     = r_err;

endmodule
